// File: rtl/ks_add_sequencer_if.sv
// Request, shared-adder and response bundle for ks_add_sequencer.
// slave = the sequencer; master = requesters, the shared adder and the result consumer.
`timescale 1ns/1ps
interface ks_add_sequencer_if #(
    parameter int NCHUNK = 4
);
    localparam int W = 16 * NCHUNK;

    logic         req0_valid;
    logic         req1_valid;
    logic         req0_ready;
    logic         req1_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req0_cin;
    logic         req1_cin;
    logic         req0_sub;
    logic         req1_sub;

    logic [15:0]  add_a;
    logic [15:0]  add_b;
    logic         add_cin;
    logic [15:0]  add_sum;
    logic         add_cout;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_cin, req1_cin, req0_sub, req1_sub,
        input  add_sum, add_cout, rsp_ready,
        output req0_ready, req1_ready, add_a, add_b, add_cin,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_cin, req1_cin, req0_sub, req1_sub,
        output add_sum, add_cout, rsp_ready,
        input  req0_ready, req1_ready, add_a, add_b, add_cin,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/ks_add_sequencer.sv
// Two-port round-robin sequencer running 16*NCHUNK-bit adds one 16-bit chunk per cycle on an external adder.
// Define KS_SEQ_SUB_EN to honour req*_sub (a - b); otherwise every operation is a + b + cin.
`timescale 1ns/1ps
module ks_add_sequencer #(
    parameter int NCHUNK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ks_add_sequencer_if.slave bus
);
    localparam int W  = 16 * NCHUNK;
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_armed;
    logic          r_last_grant;
    logic          r_id;
    logic          r_carry;
    logic [KW-1:0] r_k;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;

    logic          w_grant;
    logic          w_rdy0;
    logic          w_rdy1;
    logic          w_hs;
    logic          w_last_chunk;
    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic          w_cin;
    logic [W-1:0]  w_b_eff;
    logic          w_cin_eff;

    // Round robin on a tie; a lone requester always wins.
    assign w_grant = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    assign w_a     = w_grant ? bus.req1_a   : bus.req0_a;
    assign w_b     = w_grant ? bus.req1_b   : bus.req0_b;
    assign w_cin   = w_grant ? bus.req1_cin : bus.req0_cin;

`ifdef KS_SEQ_SUB_EN
    logic w_sub;
    assign w_sub     = w_grant ? bus.req1_sub : bus.req0_sub;
    assign w_b_eff   = w_sub ? ~w_b : w_b;
    assign w_cin_eff = w_sub | w_cin;
`else
    logic w_unused_sub;
    assign w_unused_sub = bus.req0_sub ^ bus.req1_sub;
    assign w_b_eff      = w_b;
    assign w_cin_eff    = w_cin;
`endif

    assign w_hs         = w_rdy0 | w_rdy1;
    assign w_last_chunk = (r_k == KW'(NCHUNK - 1));

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs)          w_next = RUN;
            RUN:     if (w_last_chunk)  w_next = DONE;
            DONE:    if (bus.rsp_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_comb begin
        w_rdy0        = 1'b0;
        w_rdy1        = 1'b0;
        bus.add_a     = '0;
        bus.add_b     = '0;
        bus.add_cin   = 1'b0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_rdy0 = r_armed & bus.req0_valid & ~w_grant;
                w_rdy1 = r_armed & bus.req1_valid &  w_grant;
            end
            RUN: begin
                bus.add_a   = r_a[15:0];
                bus.add_b   = r_b[15:0];
                bus.add_cin = r_carry;
            end
            DONE:    bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.rsp_sum    = r_sum;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_cout   = r_carry;

    // Operands shift right one chunk per RUN cycle; the sum fills from the top, so chunk 0 ends at the bottom.
    // r_carry is preloaded with the effective carry-in, so chunk 0 needs no special case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed      <= 1'b0;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_carry      <= 1'b0;
            r_k          <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
        end else begin
            r_armed <= 1'b1;
            if (w_hs) begin
                r_a          <= w_a;
                r_b          <= w_b_eff;
                r_carry      <= w_cin_eff;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
                r_k          <= '0;
            end else if (r_state == RUN) begin
                r_a     <= r_a >> 16;
                r_b     <= r_b >> 16;
                r_sum   <= {bus.add_sum, r_sum[W-1:16]};
                r_carry <= bus.add_cout;
                r_k     <= r_k + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ks_add_sequencer.sv
// Scoreboard bench for ks_add_sequencer with a behavioural model of the shared 16-bit adder.
// Expected responses are queued at each request handshake and popped on each response handshake.
`timescale 1ns/1ps
module tb_ks_add_sequencer;
    localparam int NCHUNK = 4;
    localparam int W      = 16 * NCHUNK;
`ifdef KS_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;
    int unsigned last_hs_cyc = 0;

    ks_add_sequencer_if #(.NCHUNK(NCHUNK)) bus ();
    ks_add_sequencer #(.NCHUNK(NCHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W:0] r;
        exp_t       e;
        if (sub && SUB_EN) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else               r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        e.id   = id;
        e.sum  = r[W-1:0];
        e.cout = r[W];
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got id=%0d sum=%h cout=%0d, expected no response",
                             bus.rsp_id, bus.rsp_sum, bus.rsp_cout);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({bus.rsp_id, bus.rsp_sum, bus.rsp_cout} !== mon_e) begin
                        n_err++;
                        $display("FAIL sb_rsp: got id=%0d sum=%h cout=%0d, expected id=%0d sum=%h cout=%0d",
                                 bus.rsp_id, bus.rsp_sum, bus.rsp_cout, mon_e.id, mon_e.sum, mon_e.cout);
                    end
                end
            end
            if (bus.req0_valid && bus.req0_ready)
                sb_q.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_cin, bus.req0_sub));
            if (bus.req1_valid && bus.req1_ready)
                sb_q.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_cin, bus.req1_sub));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0; bus.req0_sub = 1'b0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0; bus.req1_sub = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drive_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic sub);
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_sub = sub; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_sub = sub; bus.req0_valid = 1'b1;
        end
    endtask

    // Returns in the first DONE cycle; lat counts cycles from the handshake edge, cin_seq holds add_cin per RUN cycle.
    task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          output int lat, output logic [NCHUNK-1:0] cin_seq);
        int n;
        lat     = 0;
        cin_seq = '0;
        drive_req(id, a, b, cin, sub);
        #1;
        n = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_vec++; n_err++;
            $display("FAIL hs_timeout: req%0d ready not seen in 20 cycles, expected a grant", id);
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            return;
        end
        tick();
        last_hs_cyc = cyc;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            if (lat <= NCHUNK) cin_seq[lat-1] = bus.add_cin;
            tick();
            lat++;
        end
        if (!bus.rsp_valid) begin
            n_vec++; n_err++;
            $display("FAIL rsp_timeout: rsp_valid=0 after 40 cycles, expected 1");
        end
    endtask

    task automatic finish_rsp();
        int n;
        bus.rsp_ready = 1'b1;
        n = 0;
        while (bus.rsp_valid && n < 10) begin
            tick();
            n++;
        end
        if (bus.rsp_valid) begin
            n_vec++; n_err++;
            $display("FAIL rsp_drain: rsp_valid still 1 after 10 cycles, expected 0");
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.add_cin} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got rdy0/rdy1/valid/id/cout/add_cin=%b, expected 000000",
                     {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.add_cin});
        end
        n_vec++;
        if (bus.rsp_sum !== '0) begin
            n_err++;
            $display("FAIL reset_sum: got %h, expected 0", bus.rsp_sum);
        end
        n_vec++;
        if ({bus.add_a, bus.add_b} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_add: got add_a=%h add_b=%h, expected 0/0", bus.add_a, bus.add_b);
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_carry_chain();
        int                lat;
        logic [NCHUNK-1:0] seq;
        bus.rsp_ready = 1'b1;
        run_op(1'b0, {W{1'b1}}, W'(1), 1'b0, 1'b0, lat, seq);
        n_vec++;
        if (lat !== NCHUNK + 1) begin
            n_err++;
            $display("FAIL chain_latency: rsp_valid at T+%0d, expected T+%0d", lat, NCHUNK + 1);
        end
        n_vec++;
        if ({bus.rsp_id, bus.rsp_sum, bus.rsp_cout} !== {1'b0, {W{1'b0}}, 1'b1}) begin
            n_err++;
            $display("FAIL chain_result: got id=%0d sum=%h cout=%0d, expected id=0 sum=0 cout=1",
                     bus.rsp_id, bus.rsp_sum, bus.rsp_cout);
        end
        finish_rsp();
    endtask

    task automatic test_carry_seq();
        int                lat;
        logic [NCHUNK-1:0] seq;
        bus.rsp_ready = 1'b1;
        run_op(1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat, seq);
        n_vec++;
        if (seq !== 4'b0110) begin
            n_err++;
            $display("FAIL cin_seq: got chunk3..0=%b, expected 0110", seq);
        end
        n_vec++;
        if ({bus.rsp_sum, bus.rsp_cout} !== {64'h0000_0001_0000_0000, 1'b0}) begin
            n_err++;
            $display("FAIL cin_seq_result: got sum=%h cout=%0d, expected 0000000100000000/0",
                     bus.rsp_sum, bus.rsp_cout);
        end
        finish_rsp();
    endtask

    task automatic test_round_robin();
        int          n;
        int unsigned prev;
        do_reset();
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 64'h0000_1234_0000_5678, 64'h0000_0000_0000_1111, 1'b0, 1'b0);
        drive_req(1'b1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 1'b1, 1'b0);
        #1;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
                tick();
                n++;
            end
            n_vec++;
            if (n >= 20) begin
                n_err++;
                $display("FAIL rr_timeout: grant %0d not seen in 20 cycles, expected a grant", g);
                break;
            end
            if ((bus.req0_ready && bus.req1_ready) || (bus.req1_ready !== g[0])) begin
                n_err++;
                $display("FAIL rr_grant%0d: got rdy0=%0d rdy1=%0d, expected only req%0d", g,
                         bus.req0_ready, bus.req1_ready, g[0]);
            end
            tick();
            if (g > 0) begin
                n_vec++;
                if (cyc - prev !== NCHUNK + 2) begin
                    n_err++;
                    $display("FAIL rr_spacing: got %0d cycles between grants, expected %0d", cyc - prev, NCHUNK + 2);
                end
            end
            prev = cyc;
        end
        idle_inputs();
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        finish_rsp();
    endtask

    task automatic test_backpressure();
        int                lat;
        logic [NCHUNK-1:0] seq;
        exp_t              e;
        e = model(1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
        bus.rsp_ready = 1'b0;
        run_op(1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0, lat, seq);
        drive_req(1'b0, 64'h5, 64'h6, 1'b0, 1'b0);
        drive_req(1'b1, 64'h7, 64'h8, 1'b0, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got valid=%0d id=%0d sum=%h cout=%0d, expected 1/%0d/%h/%0d", i,
                         bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, e.id, e.sum, e.cout);
            end
            n_vec++;
            if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
                n_err++;
                $display("FAIL bp_no_grant%0d: got rdy0=%0d rdy1=%0d, expected 0/0", i,
                         bus.req0_ready, bus.req1_ready);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        idle_inputs();
        n_vec++;
        if (bus.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: got rsp_valid=%0d after accept, expected 0", bus.rsp_valid);
        end
    endtask

    task automatic test_sub();
        int                lat;
        logic [NCHUNK-1:0] seq;
        bus.rsp_ready = 1'b1;
        run_op(1'b1, 64'h10, 64'h11, 1'b0, 1'b1, lat, seq);
        n_vec++;
        if ({bus.rsp_id, bus.rsp_sum, bus.rsp_cout} !== {1'b1, (SUB_EN ? {W{1'b1}} : W'(64'h21)), 1'b0}) begin
            n_err++;
            $display("FAIL sub_borrow: got id=%0d sum=%h cout=%0d, expected id=1 sum=%h cout=0",
                     bus.rsp_id, bus.rsp_sum, bus.rsp_cout, SUB_EN ? {W{1'b1}} : W'(64'h21));
        end
        finish_rsp();
        run_op(1'b0, 64'h20, 64'h11, 1'b1, 1'b1, lat, seq);
        n_vec++;
        if ({bus.rsp_sum, bus.rsp_cout} !== (SUB_EN ? {W'(64'hF), 1'b1} : {W'(64'h32), 1'b0})) begin
            n_err++;
            $display("FAIL sub_noborrow: got sum=%h cout=%0d, expected %s", bus.rsp_sum, bus.rsp_cout,
                     SUB_EN ? "f/1" : "32/0");
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid_run();
        int                n;
        int                lat;
        logic [NCHUNK-1:0] seq;
        logic              seen;
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0, 1'b0);
        #1;
        n = 0;
        while (!bus.req0_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        idle_inputs();
        tick();
        tick();
        n_vec++;
        if (bus.add_a !== 16'h2222) begin
            n_err++;
            $display("FAIL mid_chunk2: got add_a=%h, expected 2222", bus.add_a);
        end
        drive_req(1'b1, 64'h9, 64'h9, 1'b0, 1'b0);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        n_vec++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.add_cin,
             bus.add_a, bus.add_b, bus.rsp_sum} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got rdy=%b%b valid=%0d id=%0d cout=%0d add=%h/%h/%0d sum=%h, expected all 0",
                     bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_cout,
                     bus.add_a, bus.add_b, bus.add_cin, bus.rsp_sum);
        end
        idle_inputs();
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen |= bus.rsp_valid;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL mid_no_rsp: got rsp_valid=1 after abort, expected 0");
        end
        run_op(1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0, lat, seq);
        n_vec++;
        if ({bus.rsp_sum, bus.rsp_cout} !== {64'h0000_0001_0000_0000, 1'b1}) begin
            n_err++;
            $display("FAIL mid_recover: got sum=%h cout=%0d, expected 0000000100000000/1",
                     bus.rsp_sum, bus.rsp_cout);
        end
        finish_rsp();
    endtask

    task automatic test_random();
        int                lat;
        logic [NCHUNK-1:0] seq;
        logic [W-1:0]      a;
        logic [W-1:0]      b;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            run_op(1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat, seq);
            finish_rsp();
        end
    endtask

    initial begin
        idle_inputs();
        bus.rsp_ready = 1'b0;
        test_reset();
        test_carry_chain();
        test_carry_seq();
        test_round_robin();
        test_backpressure();
        test_sub();
        test_reset_mid_run();
        test_random();
        repeat (3) tick();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d responses outstanding, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
